// File: rtl/aes_key_expand_pkg.sv
// Shared AES definitions for the key expander and the cipher pipeline:
// S-box table, SubWord/RotWord/xtime helpers, Rcon start value and FSM states.
package aes_key_expand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ke_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // FIPS-197 S-box, entry 0x00 in the MSBs, one 16-entry row per literal.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // GF(2^8) doubling, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on a 32-bit word; the only S-box hardware
// used by the key expander.
module aes_sub_word
  import aes_key_expand_pkg::*;
(
  input  logic [31:0] data,
  output logic [31:0] result
);

  assign result = sub_word(data);

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key expansion: one schedule word per clock, round keys
// exposed straight from the word register array.
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [Nk*32-1:0] key,
  output logic [127:0]     k_sch [0:Nr],
  output logic             busy,
  output logic             key_valid
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);

  ke_state_e       state_r, state_nxt_s;
  logic [31:0]     w_r [0:NW-1];
  logic [IW-1:0]   idx_r;
  logic [2:0]      kmod_r;
  logic [7:0]      rcon_r;
  logic            busy_r, busy_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            step_s, last_s;
  logic [31:0]     prev_s, back_s, sub_in_s, sub_out_s, temp_s;

  assign last_s = (idx_r == IW'(NW - 1));
  assign prev_s = w_r[idx_r - IW'(1)];
  assign back_s = w_r[idx_r - IW'(Nk)];

  aes_sub_word u_sub_word (
    .data   (sub_in_s),
    .result (sub_out_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; key_load restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (key_load) state_nxt_s = ST_EXPAND; else state_nxt_s = ST_IDLE;
      ST_EXPAND: begin
        if (key_load)    state_nxt_s = ST_EXPAND;
        else if (last_s) state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_EXPAND;
      end
      ST_DONE:   if (key_load) state_nxt_s = ST_EXPAND; else state_nxt_s = ST_DONE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/control decode: step enable and next busy/valid flags.
  always_comb begin
    step_s      = 1'b0;
    busy_nxt_s  = busy_r;
    valid_nxt_s = valid_r;
    if (key_load) begin
      busy_nxt_s  = 1'b1;
      valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_nxt_s  = 1'b0;
          valid_nxt_s = 1'b0;
        end
        ST_EXPAND: begin
          step_s = 1'b1;
          if (last_s) begin
            busy_nxt_s  = 1'b0;
            valid_nxt_s = 1'b1;
          end else begin
            busy_nxt_s  = 1'b1;
            valid_nxt_s = 1'b0;
          end
        end
        ST_DONE: begin
          busy_nxt_s  = 1'b0;
          valid_nxt_s = valid_r;
        end
        default: begin
          busy_nxt_s  = 1'b0;
          valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Temp word derivation from w[i-1] depending on position within the key period.
  always_comb begin
    sub_in_s = prev_s;
    temp_s   = prev_s;
    if (kmod_r == 3'd0) begin
      sub_in_s = rot_word(prev_s);
      temp_s   = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((Nk == 8) && (kmod_r == 3'd4)) begin
      sub_in_s = prev_s;
      temp_s   = sub_out_s;
    end else begin
      sub_in_s = prev_s;
      temp_s   = prev_s;
    end
  end

  // Schedule word array: key load, then one word per cycle in EXPAND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NW; j++) w_r[j] <= 32'h0;
    end else if (key_load) begin
      for (int j = 0; j < Nk; j++) w_r[j] <= key[(Nk - j) * 32 - 1 -: 32];
    end else if (step_s) begin
      w_r[idx_r] <= back_s ^ temp_s;
    end
  end

  // Index, key-period position and Rcon; Rcon only advances while another use remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= '0;
      kmod_r <= 3'd0;
      rcon_r <= RCON_INIT;
    end else if (key_load) begin
      idx_r  <= IW'(Nk);
      kmod_r <= 3'd0;
      rcon_r <= RCON_INIT;
    end else if (step_s) begin
      if (!last_s) idx_r <= idx_r + IW'(1);
      kmod_r <= (kmod_r == 3'(Nk - 1)) ? 3'd0 : kmod_r + 3'd1;
      if ((kmod_r == 3'd0) && (idx_r <= IW'(NW - 1 - Nk))) rcon_r <= xtime(rcon_r);
    end
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign key_valid = valid_r;

  for (genvar r = 0; r <= Nr; r++) begin : g_ksch
    assign k_sch[r] = {w_r[4*r], w_r[4*r+1], w_r[4*r+2], w_r[4*r+3]};
  end

endmodule
